// File: rtl/mem_pkg.sv
// Shared definitions for the load/store responder.
// Funct3 access encodings, FSM states and lane helpers.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RD_WAIT,
    RD_DONE,
    HALTED
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  function automatic logic load_ok(
    input logic [2:0] f3,
    input logic [1:0] off
  );
    logic ok;
    case (f3)
      F3_B, F3_BU: ok = 1'b1;
      F3_H, F3_HU: ok = ~off[0];
      F3_W:        ok = (off == 2'b00);
      default:     ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic store_ok(
    input logic [2:0] f3,
    input logic [1:0] off
  );
    logic ok;
    case (f3)
      F3_B:    ok = 1'b1;
      F3_H:    ok = ~off[0];
      F3_W:    ok = (off == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [3:0] store_mask(
    input logic [2:0] f3,
    input logic [1:0] off
  );
    logic [3:0] m;
    case (f3)
      F3_B:    m = 4'b0001 << off;
      F3_H:    m = off[1] ? 4'b1100 : 4'b0011;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  function automatic logic [31:0] store_data(
    input logic [2:0]  f3,
    input logic [31:0] wd
  );
    logic [31:0] d;
    case (f3)
      F3_B:    d = {4{wd[7:0]}};
      F3_H:    d = {2{wd[15:0]}};
      default: d = wd;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/load_extend.sv
// Picks the addressed byte/half out of a read word
// and sign- or zero-extends it to 32 bits.
module load_extend
  import mem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  byte_off,
  input  logic [31:0] rdata,
  output logic [31:0] result
);

  logic [7:0]  sel_b;
  logic [15:0] sel_h;

  // lane select by byte offset
  always_comb begin
    sel_b = rdata[7:0];
    unique case (byte_off)
      2'd0: sel_b = rdata[7:0];
      2'd1: sel_b = rdata[15:8];
      2'd2: sel_b = rdata[23:16];
      2'd3: sel_b = rdata[31:24];
    endcase
    sel_h = byte_off[1] ? rdata[31:16] : rdata[15:0];
  end

  // size/sign extension
  always_comb begin
    result = rdata;
    case (funct3)
      F3_B:    result = {{24{sel_b[7]}}, sel_b};
      F3_BU:   result = {24'h0, sel_b};
      F3_H:    result = {{16{sel_h[15]}}, sel_h};
      F3_HU:   result = {16'h0, sel_h};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_responder.sv
// Data-memory responder: single-cycle stores, 3-cycle loads,
// sticky misalignment error and halt handling.
module mem_responder
  import mem_pkg::*;
#(
  parameter int MEM_AW = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [2:0]        Funct3,
  input  logic [31:0]       Addr,
  input  logic [31:0]       WrData,
  input  logic              haltPut,
  output logic [31:0]       RdData,
  output logic              Stall,
  output logic              MisalignErr,
  output logic              Halted,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  state_t      state;
  logic [2:0]  ld_f3;
  logic [1:0]  ld_off;
  logic        halt_pend;
  logic [31:0] ext_data;

  logic idle;
  logic legal_ld;
  logic legal_st;
  logic do_ld;
  logic do_st;
  logic req_err;

  logic unused_addr;
  assign unused_addr = ^Addr[31:MEM_AW+2];

  load_extend u_ext (
    .funct3   (ld_f3),
    .byte_off (ld_off),
    .rdata    (mem_rdata),
    .result   (ext_data)
  );

  // classify the request seen in IDLE
  always_comb begin
    idle     = (state == IDLE) && !reset;
    legal_ld = MemRead && !MemWrite
             && load_ok(Funct3, Addr[1:0]);
    legal_st = MemWrite && !MemRead
             && store_ok(Funct3, Addr[1:0]);
    do_ld    = idle && legal_ld;
    do_st    = idle && legal_st;
    req_err  = idle && (MemRead || MemWrite)
             && !legal_ld && !legal_st;
  end

  // SRAM strobes and core hold, same cycle as the request
  always_comb begin
    mem_en    = do_ld || do_st;
    mem_we    = do_st ? store_mask(Funct3, Addr[1:0])
                      : 4'b0000;
    mem_addr  = Addr[MEM_AW+1:2];
    mem_wdata = store_data(Funct3, WrData);
    Stall     = !reset
             && (do_ld || state == RD_WAIT);
  end

  // control FSM with registered status and load result
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      RdData      <= 32'h0;
      MisalignErr <= 1'b0;
      Halted      <= 1'b0;
      halt_pend   <= 1'b0;
      ld_f3       <= 3'b000;
      ld_off      <= 2'b00;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_err) begin
            MisalignErr <= 1'b1;
            Halted      <= 1'b1;
            state       <= HALTED;
          end else if (legal_ld) begin
            ld_f3     <= Funct3;
            ld_off    <= Addr[1:0];
            halt_pend <= haltPut;
            state     <= RD_WAIT;
          end else if (haltPut) begin
            Halted <= 1'b1;
            state  <= HALTED;
          end
        end
        RD_WAIT: begin
          RdData    <= ext_data;
          halt_pend <= halt_pend | haltPut;
          state     <= RD_DONE;
        end
        RD_DONE: begin
          halt_pend <= 1'b0;
          if (halt_pend || haltPut) begin
            Halted <= 1'b1;
            state  <= HALTED;
          end else begin
            state <= IDLE;
          end
        end
        HALTED: begin
          state <= HALTED;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: byte-level reference memory model,
// directed literal cases then randomized traffic.
module tb_mem_responder;

  localparam int MEM_AW = 9;
  localparam int NBYTES = 4 << MEM_AW;

  logic              clk;
  logic              reset;
  logic              MemRead;
  logic              MemWrite;
  logic [2:0]        Funct3;
  logic [31:0]       Addr;
  logic [31:0]       WrData;
  logic              haltPut;
  logic [31:0]       RdData;
  logic              Stall;
  logic              MisalignErr;
  logic              Halted;
  logic              mem_en;
  logic [3:0]        mem_we;
  logic [MEM_AW-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  mem_responder #(.MEM_AW(MEM_AW)) dut (
    .clk         (clk),
    .reset       (reset),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .Funct3      (Funct3),
    .Addr        (Addr),
    .WrData      (WrData),
    .haltPut     (haltPut),
    .RdData      (RdData),
    .Stall       (Stall),
    .MisalignErr (MisalignErr),
    .Halted      (Halted),
    .mem_en      (mem_en),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  // bench SRAM driven only by the DUT strobes
  bit [31:0] sram [0:(1<<MEM_AW)-1];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we == 4'b0000)
        mem_rdata <= sram[mem_addr];
      else
        for (int i = 0; i < 4; i++)
          if (mem_we[i])
            sram[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
    end
  end

  // reference model: byte memory plus load progress
  bit [7:0]    refmem [0:NBYTES-1];
  int          ph = 0;
  logic [31:0] m_rd = 32'h0;
  logic        m_err = 1'b0;
  logic        m_halt = 1'b0;
  logic        m_hp = 1'b0;
  logic [31:0] m_pend = 32'h0;

  function automatic int access_size(input logic [2:0] f);
    case (f)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      3'b010:         return 4;
      default:        return 0;
    endcase
  endfunction

  function automatic logic [31:0] load_ref(input int ba,
                                           input int n,
                                           input logic uns);
    logic [31:0] v;
    v = 32'h0;
    for (int k = 0; k < n; k++)
      v = v | (32'(refmem[ba+k]) << (8*k));
    if (!uns && n < 4 && v[8*n-1])
      v = v | (32'hFFFF_FFFF << (8*n));
    return v;
  endfunction

  // compare DUT against model, then advance model
  always @(negedge clk) begin
    logic       e_en;
    logic       e_stall;
    logic [3:0] e_we;
    logic       legal;
    int         ba;
    int         n;
    int         b;
    e_en = 1'b0;
    e_we = 4'b0000;
    e_stall = 1'b0;
    ba = int'(Addr[MEM_AW+1:0]);
    chk("rd_data", RdData, m_rd);
    chk("misalign_err", 32'(MisalignErr), 32'(m_err));
    chk("halted", 32'(Halted), 32'(m_halt));
    if (reset) begin
      ph = 0;
      m_rd = 32'h0;
      m_err = 1'b0;
      m_halt = 1'b0;
      m_hp = 1'b0;
    end else begin
      case (ph)
        0: begin
          if (MemRead || MemWrite) begin
            n = access_size(Funct3);
            legal = !(MemRead && MemWrite) && n != 0
                 && (ba % (n == 0 ? 1 : n)) == 0
                 && (MemRead || !Funct3[2]);
            if (!legal) begin
              m_err = 1'b1;
              m_halt = 1'b1;
              ph = 3;
            end else if (MemRead) begin
              e_en = 1'b1;
              e_stall = 1'b1;
              m_pend = load_ref(ba, n, Funct3[2]);
              m_hp = haltPut;
              ph = 1;
            end else begin
              e_en = 1'b1;
              for (int k = 0; k < n; k++) begin
                b = ba + k;
                e_we[b%4] = 1'b1;
                chk("wdata_lane",
                    32'(mem_wdata[8*(b%4) +: 8]),
                    32'(WrData[8*k +: 8]));
                refmem[b] = WrData[8*k +: 8];
              end
              if (haltPut) begin
                m_halt = 1'b1;
                ph = 3;
              end
            end
          end else if (haltPut) begin
            m_halt = 1'b1;
            ph = 3;
          end
        end
        1: begin
          e_stall = 1'b1;
          m_rd = m_pend;
          m_hp = m_hp | haltPut;
          ph = 2;
        end
        2: begin
          if (m_hp || haltPut) begin
            m_halt = 1'b1;
            ph = 3;
          end else begin
            ph = 0;
          end
          m_hp = 1'b0;
        end
        default: ;
      endcase
    end
    chk("stall", 32'(Stall), 32'(e_stall));
    chk("mem_en", 32'(mem_en), 32'(e_en));
    chk("mem_we", 32'(mem_we), 32'(e_we));
    if (e_en)
      chk("mem_addr", 32'(mem_addr),
          32'(Addr[MEM_AW+1:2]));
  end

  task automatic step(input logic r,
                      input logic rd,
                      input logic wr,
                      input logic [2:0] f,
                      input logic [31:0] a,
                      input logic [31:0] wd,
                      input logic hp);
    @(posedge clk);
    #1;
    reset = r;
    MemRead = rd;
    MemWrite = wr;
    Funct3 = f;
    Addr = a;
    WrData = wd;
    haltPut = hp;
  endtask

  task automatic idle();
    step(0, 0, 0, 3'b000, 32'h0, 32'h0, 0);
  endtask

  initial begin
    reset = 1'b1;
    MemRead = 1'b0;
    MemWrite = 1'b0;
    Funct3 = 3'b000;
    Addr = 32'h0;
    WrData = 32'h0;
    haltPut = 1'b0;

    step(1, 0, 0, 3'b000, 32'h0, 32'h0, 0);
    step(1, 0, 0, 3'b000, 32'h0, 32'h0, 0);
    #2;
    chk("rst_stall", 32'(Stall), 32'h0);
    chk("rst_mem_en", 32'(mem_en), 32'h0);
    chk("rst_mem_we", 32'(mem_we), 32'h0);
    chk("rst_rd_data", RdData, 32'h0);
    chk("rst_err", 32'(MisalignErr), 32'h0);
    chk("rst_halted", 32'(Halted), 32'h0);

    step(0, 0, 1, 3'b010, 32'h10, 32'hDEADBEEF, 0);
    #2;
    chk("sw_en", 32'(mem_en), 32'h1);
    chk("sw_we", 32'(mem_we), 32'hF);
    chk("sw_addr", 32'(mem_addr), 32'h4);
    chk("sw_stall", 32'(Stall), 32'h0);
    chk("sw_wdata", mem_wdata, 32'hDEADBEEF);

    step(0, 0, 1, 3'b000, 32'h13, 32'h000000A5, 0);
    #2;
    chk("sb_we", 32'(mem_we), 32'h8);
    chk("sb_wdata", mem_wdata, 32'hA5A5A5A5);

    step(0, 0, 1, 3'b010, 32'h20, 32'h0080FF00, 0);
    step(0, 0, 1, 3'b010, 32'h04, 32'h12348765, 0);

    step(0, 1, 0, 3'b000, 32'h22, 32'h0, 0);
    #2;
    chk("lb_stall0", 32'(Stall), 32'h1);
    idle();
    #2;
    chk("lb_stall1", 32'(Stall), 32'h1);
    idle();
    #2;
    chk("lb_stall2", 32'(Stall), 32'h0);
    chk("lb_data", RdData, 32'hFFFFFF80);

    step(0, 1, 0, 3'b100, 32'h22, 32'h0, 0);
    idle();
    idle();
    #2;
    chk("lbu_data", RdData, 32'h00000080);

    step(0, 1, 0, 3'b001, 32'h04, 32'h0, 1);
    idle();
    idle();
    #2;
    chk("lh_halt_data", RdData, 32'hFFFF8765);
    chk("lh_halt_pre", 32'(Halted), 32'h0);
    idle();
    #2;
    chk("lh_halt_post", 32'(Halted), 32'h1);

    step(1, 0, 0, 3'b000, 32'h0, 32'h0, 0);
    step(0, 1, 0, 3'b010, 32'h06, 32'h0, 0);
    #2;
    chk("mis_mem_en", 32'(mem_en), 32'h0);
    idle();
    #2;
    chk("mis_err", 32'(MisalignErr), 32'h1);
    chk("mis_halted", 32'(Halted), 32'h1);
    step(0, 0, 1, 3'b010, 32'h10, 32'h1, 0);
    #2;
    chk("halted_ignore", 32'(mem_en), 32'h0);

    step(1, 0, 0, 3'b000, 32'h0, 32'h0, 0);
    step(0, 1, 0, 3'b010, 32'h20, 32'h0, 0);
    idle();
    idle();
    #2;
    chk("lw_data", RdData, 32'h0080FF00);
    step(0, 1, 0, 3'b010, 32'h24, 32'h0, 0);
    step(1, 0, 0, 3'b000, 32'h0, 32'h0, 0);
    idle();
    #2;
    chk("rst_mid_stall", 32'(Stall), 32'h0);
    chk("rst_mid_data", RdData, 32'h0);
    idle();
    #2;
    chk("rst_mid_hold", RdData, 32'h0);

    for (int c = 0; c < 3000; c++) begin
      logic        r;
      logic        rd;
      logic        wr;
      logic        hp;
      logic [2:0]  f;
      logic [31:0] a;
      int          op;
      int          fs;
      r = (m_halt && $urandom_range(0, 3) == 0)
       || $urandom_range(0, 199) == 0;
      op = int'($urandom_range(0, 9));
      rd = (op <= 3) || (op == 9);
      wr = (op >= 4 && op <= 7) || (op == 9);
      fs = int'($urandom_range(0, 19));
      case (fs % 8)
        0, 5:    f = 3'b000;
        1, 6:    f = 3'b001;
        2, 7:    f = 3'b010;
        3:       f = 3'b100;
        default: f = 3'b101;
      endcase
      if (fs >= 18) f = (fs == 18) ? 3'b011 : 3'b111;
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a[10:5] = 6'h0;
      if ($urandom_range(0, 9) != 0) begin
        if (f[1:0] == 2'b10) a[1:0] = 2'b00;
        if (f[1:0] == 2'b01) a[0] = 1'b0;
      end
      hp = ($urandom_range(0, 39) == 0);
      step(r, rd, wr, f, a, $urandom, hp);
    end

    idle();
    @(posedge clk);
    #2;
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter MEM_AW, default 9, meaning word-address width of the attached data SRAM.
REQ-002 SHALL have port clk  input  1  single system clock, all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports MemRead  input  1  and MemWrite  input  1  as load/store requests from the core control path.
REQ-005 SHALL have port Funct3  input  3  access size/sign: 000 lb/sb, 001 lh/sh, 010 lw/sw, 100 lbu, 101 lhu.
REQ-006 SHALL have ports Addr  input  32  byte address, WrData  input  32  store data, haltPut  input  1  halt request.
REQ-007 SHALL have ports RdData  output  32  extended load result, Stall  output  1  core hold, MisalignErr  output  1  sticky error, Halted  output  1  halted status.
REQ-008 SHALL have SRAM ports mem_en  output  1, mem_we  output  4  byte enables, mem_addr  output  MEM_AW  word address, mem_wdata  output  32, mem_rdata  input  32  valid one cycle after a read enable.

Function
REQ-009 SHALL implement FSM states IDLE, RD_WAIT, RD_DONE, HALTED.
REQ-010 IDLE, legal MemWrite: SHALL drive mem_en=1 and mem_we/mem_wdata the same cycle, Stall=0, remain IDLE (single-cycle store).
REQ-011 Store lanes SHALL be: sb mem_we=0001<<Addr[1:0], WrData[7:0] replicated x4; sh mem_we=0011 (Addr[1]=0) or 1100, WrData[15:0] replicated x2; sw mem_we=1111.
REQ-012 IDLE, legal MemRead: SHALL drive mem_en=1, mem_we=0000, Stall=1, next state RD_WAIT.
REQ-013 RD_WAIT: SHALL register extended mem_rdata into RdData, Stall=1, mem_en=0, next state RD_DONE.
REQ-014 RD_DONE: SHALL hold RdData, Stall=0, ignore requests this cycle, next state IDLE; load latency is 3 cycles from request to retire.
REQ-015 Load extension SHALL select byte/half by Addr[1:0]/Addr[1]: lb/lh sign-extend, lbu/lhu zero-extend, lw pass-through.
REQ-016 mem_addr SHALL be Addr[MEM_AW+1:2]; upper address bits ignored (wrap-around).
REQ-017 Misaligned (half with Addr[0]=1, word with Addr[1:0]!=00), illegal Funct3 (011,110,111 or store with 1xx), or MemRead&MemWrite together SHALL suppress mem_en, set MisalignErr=1 sticky, enter HALTED next cycle.
REQ-018 haltPut in IDLE with no request SHALL enter HALTED next cycle; haltPut with a legal request SHALL service the request first (store same cycle, load completes) then enter HALTED from IDLE/RD_DONE.
REQ-019 haltPut in RD_WAIT/RD_DONE SHALL be latched and honoured on load completion.
REQ-020 HALTED: Halted=1, Stall=0, mem_en=0, all requests ignored, exit only by reset.
REQ-021 RdData SHALL hold its last loaded value outside RD_WAIT updates.

Reset
REQ-022 reset SHALL force state IDLE, RdData=0, MisalignErr=0, Halted=0, latched halt=0, Stall=0, mem_en=0, mem_we=0000.
REQ-023 reset mid-read (RD_WAIT/RD_DONE) SHALL abandon the load; no RdData update from the pending mem_rdata.

Structure
REQ-024 Funct3 encodings and the state enum SHALL live in shared package mem_pkg.
REQ-025 Load byte/half selection and extension SHALL be one combinational sub-module load_extend.

Verification
REQ-026 sw Addr=0x10 WrData=0xDEADBEEF -> same cycle mem_en=1, mem_we=1111, mem_addr=4, Stall=0.
REQ-027 sb Addr=0x13 WrData=0x000000A5 -> mem_we=1000, mem_wdata=0xA5A5A5A5.
REQ-028 lb Addr=0x22, mem_rdata=0x0080FF00 -> Stall 1,1,0; RdData=0xFFFFFF80 in RD_DONE; lbu same -> 0x00000080.
REQ-029 lw Addr=0x06 -> no mem_en, MisalignErr=1 next cycle, Halted=1, later requests ignored until reset.
REQ-030 lh Addr=0x04 with haltPut=1 -> load completes (RdData valid in RD_DONE), then Halted=1.
REQ-031 reset asserted in RD_WAIT -> next cycle IDLE, RdData=0, Stall=0.
